// File: rtl/spi_master_ctrl.sv
// SPI master for the SPI_Slave / single-port RAM subsystem.
// Each accepted host command becomes one SS_n-framed transaction: a START
// cycle, 11 MOSI bits (op[1], op[1], op[0], payload MSB first), then for
// rd-data frames an optional turnaround and 8 MISO samples. SCK is the system
// clock, so there is no clock divider.
module spi_master_ctrl #(
    parameter int TURNAROUND = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_payload,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    // State table
    //   state | meaning
    //   IDLE  | SS_n high, cmd_ready high, waiting for a command
    //   START | SS_n low, MOSI low for one cycle so the slave can arm
    //   SEND  | shifting the 11-bit command word out on MOSI
    //   WAIT  | rd-data turnaround while the slave fetches from RAM
    //   RECV  | sampling 8 MISO bits, MSB first
    //   GAP   | SS_n high again, still busy, enforces inter-frame spacing
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        START = 3'b001,
        SEND  = 3'b010,
        WAIT  = 3'b011,
        RECV  = 3'b100,
        GAP   = 3'b101
    } state_t;

    // One shared down-counter serves every timed state; it must hold the
    // largest load value of any of them.
    localparam int MAX_TG  = (TURNAROUND > GAP_CYCLES) ? TURNAROUND : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_TG > 11) ? MAX_TG : 11;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] LD_SEND = CW'(10);
    localparam logic [CW-1:0] LD_RECV = CW'(7);
    localparam logic [CW-1:0] LD_WAIT = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    // A GAP of zero is not meaningful; it behaves as a single cycle.
    localparam logic [CW-1:0] LD_GAP  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [10:0]     shift_q;
    logic            is_rd_q;
    logic            cmd_ready_q;
    logic            busy_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_data_q;
    logic            ss_n_q;
    logic            mosi_q;

    logic [10:0]     word_d;
    logic            is_rd_d;

    // Command word as it will go on the wire; rd-data carries dummy zeros.
    always_comb begin
        is_rd_d = (cmd_op == 2'b11);
        word_d  = {cmd_op[1], cmd_op[1], cmd_op[0], (is_rd_d ? 8'h00 : cmd_payload)};
    end

    // Frame sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            is_rd_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ss_n_q      <= 1'b1;
                    mosi_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        shift_q     <= word_d;
                        is_rd_q     <= is_rd_d;
                        state_q     <= START;
                        ss_n_q      <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                START: begin
                    mosi_q  <= shift_q[10];
                    shift_q <= {shift_q[9:0], 1'b0};
                    cnt_q   <= LD_SEND;
                    state_q <= SEND;
                end
                SEND: begin
                    if (cnt_q != '0) begin
                        mosi_q  <= shift_q[10];
                        shift_q <= {shift_q[9:0], 1'b0};
                        cnt_q   <= cnt_q - 1'b1;
                    end else begin
                        mosi_q <= 1'b0;
                        if (is_rd_q) begin
                            if (TURNAROUND == 0) begin
                                state_q <= RECV;
                                cnt_q   <= LD_RECV;
                            end else begin
                                state_q <= WAIT;
                                cnt_q   <= LD_WAIT;
                            end
                        end else begin
                            state_q <= GAP;
                            ss_n_q  <= 1'b1;
                            cnt_q   <= LD_GAP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= RECV;
                        cnt_q   <= LD_RECV;
                    end
                end
                RECV: begin
                    rsp_data_q <= {rsp_data_q[6:0], MISO};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q     <= GAP;
                        ss_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        cnt_q       <= LD_GAP;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ss_n_q      <= 1'b1;
                    mosi_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: host-side reference model feeds frame and
// response scoreboards; a behavioural slave+RAM decodes MOSI and drives MISO.
module tb_spi_master_ctrl;

    localparam int TA = 3;
    localparam int GC = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_payload = 8'h00;
    logic       MISO = 1'b0;
    logic       cmd_ready, rsp_valid, busy, SS_n, MOSI;
    logic [7:0] rsp_data;

    spi_master_ctrl #(.TURNAROUND(TA), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_payload(cmd_payload),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboards
    logic [10:0] exp_word_q[$];
    int          exp_len_q[$];
    logic [7:0]  exp_rsp_q[$];

    // host-side reference of the slave RAM
    logic [7:0] ref_mem[256];
    logic [7:0] ref_wa = 8'h00, ref_ra = 8'h00;

    // behavioural slave
    logic [7:0]  sl_mem[256];
    logic [7:0]  sl_wa = 8'h00, sl_ra = 8'h00, sl_byte = 8'h00;
    logic [10:0] rx = '0;
    logic        in_frame = 1'b0, mosi_extra = 1'b0;
    int          k = 0, hi_cnt = 0, last_hi = 0, frames_started = 0;
    logic [10:0] ew;
    int          el;
    logic [7:0]  er;

    // Frame monitor / slave, evaluated mid-cycle when DUT outputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            k        = 0;
            hi_cnt   = 0;
            MISO     = 1'b0;
        end else if (!SS_n) begin
            if (!in_frame) begin
                in_frame   = 1'b1;
                k          = 0;
                rx         = '0;
                mosi_extra = 1'b0;
                last_hi    = hi_cnt;
                frames_started++;
            end
            if (k >= 1 && k <= 11) rx = {rx[9:0], MOSI};
            else mosi_extra = mosi_extra | MOSI;
            if (k == 11) begin
                case ({rx[9], rx[8]})
                    2'b00: sl_wa = rx[7:0];
                    2'b01: sl_mem[sl_wa] = rx[7:0];
                    2'b10: sl_ra = rx[7:0];
                    default: sl_byte = sl_mem[sl_ra];
                endcase
            end
            if (k >= 12 + TA && k <= 19 + TA) MISO = sl_byte[7 - (k - 12 - TA)];
            else MISO = 1'b0;
            k++;
            hi_cnt = 0;
        end else begin
            if (in_frame) begin
                in_frame = 1'b0;
                if (exp_word_q.size() > 0) begin
                    ew = exp_word_q.pop_front();
                    el = exp_len_q.pop_front();
                    check_eq("frame_word", rx, ew);
                    check_eq("frame_len", k, el);
                    check_eq("mosi_low_outside_bits", mosi_extra, 0);
                end else begin
                    check_eq("frame_expected", exp_word_q.size(), 1);
                end
            end
            hi_cnt++;
            MISO = 1'b0;
        end
        if (!rst && rsp_valid) begin
            if (exp_rsp_q.size() > 0) begin
                er = exp_rsp_q.pop_front();
                check_eq("rsp_data", rsp_data, er);
            end else begin
                check_eq("rsp_expected", exp_rsp_q.size(), 1);
            end
        end
    end

    task automatic model_cmd(input logic [1:0] op, input logic [7:0] pl);
        exp_word_q.push_back({op[1], op[1], op[0], (op == 2'b11) ? 8'h00 : pl});
        exp_len_q.push_back((op == 2'b11) ? 20 + TA : 12);
        case (op)
            2'b00: ref_wa = pl;
            2'b01: ref_mem[ref_wa] = pl;
            2'b10: ref_ra = pl;
            default: exp_rsp_q.push_back(ref_mem[ref_ra]);
        endcase
    endtask

    // Waits for cmd_ready, presents one command for one edge, then scrambles cmd_*.
    task automatic send(input logic [1:0] op, input logic [7:0] pl);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check_eq("ready_timeout", t, 0);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_payload = pl;
        model_cmd(op, pl);
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_op      = 2'($urandom);
        cmd_payload = 8'($urandom);
        check_eq("accept_ssn_low", SS_n, 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_word_q.size() != 0 || exp_rsp_q.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check_eq("idle_timeout", t, 0);
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int fs;
        logic [7:0] a, d;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
            sl_mem[i]  = 8'h00;
        end

        // reset with a competing command: reset must win
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        repeat (5) @(negedge clk);
        check_eq("rst_ssn", SS_n, 1);
        check_eq("rst_mosi", MOSI, 0);
        check_eq("rst_ready", cmd_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        cmd_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", cmd_ready, 1);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_ssn", SS_n, 1);

        // single write-address frame
        send(2'b00, 8'hA5);
        check_eq("busy_in_frame", busy, 1);
        check_eq("ready_in_frame", cmd_ready, 0);
        wait_idle();

        // loopback: directed then random
        send(2'b00, 8'h3C);
        send(2'b01, 8'h96);
        send(2'b10, 8'h3C);
        send(2'b11, 8'hFF);
        wait_idle();
        for (int i = 0; i < 150; i++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            send(2'b00, a);
            send(2'b01, d);
            send(2'b10, a);
            send(2'b11, 8'($urandom));
        end
        wait_idle();

        // command held while busy, then back-to-back spacing
        send(2'b00, 8'h20);
        cmd_valid   = 1'b1;
        cmd_op      = 2'b01;
        cmd_payload = 8'h5A;
        t = 0;
        while (busy && t < 100) begin
            check_eq("ready_low_while_busy", cmd_ready, 0);
            @(negedge clk);
            t++;
        end
        check_eq("ready_after_gap", cmd_ready, 1);
        fs = frames_started;
        model_cmd(2'b01, 8'h5A);
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (frames_started == fs && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("b2b_gap_cycles", last_hi, GC + 1);
        wait_idle();

        // prime rsp_data with a nonzero read
        send(2'b10, 8'h20);
        send(2'b11, 8'h00);
        wait_idle();
        check_eq("rsp_hold_5a", rsp_data, 8'h5A);

        // reset during SEND bit 5 of a read frame
        send(2'b11, 8'h00);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_word_q.delete();
        exp_len_q.delete();
        exp_rsp_q.delete();
        @(negedge clk);
        check_eq("midrst_ssn", SS_n, 1);
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        check_eq("midrst_rsp_data", rsp_data, 0);
        check_eq("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("midrst_still_cleared", rsp_data, 0);
        send(2'b11, 8'h00);
        wait_idle();

        // stub byte C3 through the full turnaround path
        send(2'b00, 8'h77);
        send(2'b01, 8'hC3);
        send(2'b10, 8'h77);
        send(2'b11, 8'h00);
        wait_idle();
        check_eq("c3_final", rsp_data, 8'hC3);

        check_eq("sb_drained", exp_word_q.size() + exp_rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
